// File: rtl/cpu5_muldiv_pkg.sv
// cpu5_muldiv_pkg: shared op encodings, FSM state type and operand signedness
// decode for the iterative RV32M multiply/divide unit.
package cpu5_muldiv_pkg;

   localparam int MD_OP_SIZE    = 3;
   localparam int MD_STATE_SIZE = 2;

   localparam logic [MD_OP_SIZE-1:0] MD_OP_MUL    = 3'b000;
   localparam logic [MD_OP_SIZE-1:0] MD_OP_MULH   = 3'b001;
   localparam logic [MD_OP_SIZE-1:0] MD_OP_MULHSU = 3'b010;
   localparam logic [MD_OP_SIZE-1:0] MD_OP_MULHU  = 3'b011;
   localparam logic [MD_OP_SIZE-1:0] MD_OP_DIV    = 3'b100;
   localparam logic [MD_OP_SIZE-1:0] MD_OP_DIVU   = 3'b101;
   localparam logic [MD_OP_SIZE-1:0] MD_OP_REM    = 3'b110;
   localparam logic [MD_OP_SIZE-1:0] MD_OP_REMU   = 3'b111;

   typedef enum logic [MD_STATE_SIZE-1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } mdState_e;

   // Returns {aSigned, bSigned}: which operands are treated as two's complement.
   // MUL is handled as signed; its low half is identical either way.
   function automatic logic [1:0] opSignedness(input logic [MD_OP_SIZE-1:0] op);
      logic [1:0] s;
      case (op)
         MD_OP_MUL:    s = 2'b11;
         MD_OP_MULH:   s = 2'b11;
         MD_OP_MULHSU: s = 2'b10;
         MD_OP_MULHU:  s = 2'b00;
         MD_OP_DIV:    s = 2'b11;
         MD_OP_DIVU:   s = 2'b00;
         MD_OP_REM:    s = 2'b11;
         MD_OP_REMU:   s = 2'b00;
         default:      s = 2'b00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cpu5_muldiv_signfix.sv
// cpu5_muldiv_signfix: combinational sign handling. At accept it turns the raw
// operands into magnitudes plus a result sign; in FIX it negates the raw
// accumulator as needed and picks low/high/quotient/remainder.
module cpu5_muldiv_signfix
   import cpu5_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [MD_OP_SIZE-1:0] op_i,
   input  logic [XLEN-1:0]       a_i,
   input  logic [XLEN-1:0]       b_i,
   input  logic [2*XLEN-1:0]     acc_i,
   input  logic                  sign_i,
   output logic [XLEN-1:0]       magA_o,
   output logic [XLEN-1:0]       magB_o,
   output logic                  sign_o,
   output logic [XLEN-1:0]       result_o
);

   logic [1:0]        signedness;
   logic              aNeg;
   logic              bNeg;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   divSel;

   // Operand magnitudes and result sign; REM follows the dividend sign only.
   always_comb begin
      signedness = opSignedness(op_i);
      aNeg       = signedness[1] & a_i[XLEN-1];
      bNeg       = signedness[0] & b_i[XLEN-1];
      magA_o     = aNeg ? (~a_i + XLEN'(1)) : a_i;
      magB_o     = bNeg ? (~b_i + XLEN'(1)) : b_i;
      sign_o     = (op_i == MD_OP_REM) ? aNeg : (aNeg ^ bNeg);
   end

   // Final result: multiply negates the full product before picking a half,
   // divide picks quotient or remainder and then negates it.
   always_comb begin
      prod   = sign_i ? (~acc_i + (2*XLEN)'(1)) : acc_i;
      divSel = op_i[1] ? acc_i[2*XLEN-1:XLEN] : acc_i[XLEN-1:0];
      if (op_i[2]) begin
         result_o = sign_i ? (~divSel + XLEN'(1)) : divSel;
      end else if (op_i == MD_OP_MUL) begin
         result_o = prod[XLEN-1:0];
      end else begin
         result_o = prod[2*XLEN-1:XLEN];
      end
   end

endmodule

// File: rtl/cpu5_muldiv.sv
// cpu5_muldiv: iterative RV32M multiply/divide unit. One shared 2*XLEN
// accumulator serves shift-add multiply and restoring divide; divide-by-zero
// and signed overflow bypass the iteration and complete straight away.
module cpu5_muldiv
   import cpu5_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MD_OP_SIZE-1:0] in_funct3,
   input  logic [XLEN-1:0]       in_a,
   input  logic [XLEN-1:0]       in_b,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_result,
   output logic                  busy
);

   localparam int              CW       = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);

   mdState_e              state_q, state_d;
   logic [MD_OP_SIZE-1:0] op_q, op_d;
   logic                  sign_q, sign_d;
   logic [XLEN-1:0]       opnd_q, opnd_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  outValid_q, outValid_d;
   logic [XLEN-1:0]       outResult_q, outResult_d;

   logic [MD_OP_SIZE-1:0] sfOp;
   logic [XLEN-1:0]       sfMagA, sfMagB, sfResult;
   logic                  sfSign;
   logic                  divZero, divOverflow, fastHit;
   logic [XLEN-1:0]       fastResult;
   logic [XLEN:0]         mulSum, remShift, divDiff;
   logic                  divGeq;
   logic [2*XLEN-1:0]     accNext;

   // The sign unit sees the incoming op while idle and the latched op afterwards.
   assign sfOp = (state_q == MD_IDLE) ? in_funct3 : op_q;

   cpu5_muldiv_signfix #(.XLEN(XLEN)) u_signfix (
      .op_i     (sfOp),
      .a_i      (in_a),
      .b_i      (in_b),
      .acc_i    (acc_q),
      .sign_i   (sign_q),
      .magA_o   (sfMagA),
      .magB_o   (sfMagB),
      .sign_o   (sfSign),
      .result_o (sfResult)
   );

   // Architected corner cases that skip the iterative datapath.
   always_comb begin
      divZero     = (in_b == '0);
      divOverflow = ((in_funct3 == MD_OP_DIV) || (in_funct3 == MD_OP_REM)) &&
                    (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
      fastHit     = in_funct3[2] & (divZero | divOverflow);
      if (divZero) begin
         fastResult = in_funct3[1] ? in_a : '1;
      end else begin
         fastResult = in_funct3[1] ? '0 : in_a;
      end
   end

   // One iteration step: shift-add for multiply, shift/trial-subtract for divide.
   always_comb begin
      mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
      remShift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      divDiff  = remShift - {1'b0, opnd_q};
      divGeq   = (remShift >= {1'b0, opnd_q});
      if (op_q[2]) begin
         accNext = divGeq ? {divDiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                          : {remShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         accNext = acc_q[0] ? {mulSum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= MD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; flush wins over accept and over the output handshake.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = MD_IDLE;
      end else begin
         unique case (state_q)
            MD_IDLE: if (in_valid) state_d = fastHit ? MD_DONE : MD_CALC;
            MD_CALC: if (cnt_q == CW'(1)) state_d = MD_FIX;
            MD_FIX:  state_d = MD_DONE;
            MD_DONE: if (out_ready) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
         endcase
      end
   end

   // FSM outputs decoded from the registered state only.
   always_comb begin
      in_ready = (state_q == MD_IDLE);
      busy     = (state_q != MD_IDLE);
   end

   // Datapath next state: latch operands at accept, iterate in CALC, publish in FIX.
   always_comb begin
      op_d        = op_q;
      sign_d      = sign_q;
      opnd_d      = opnd_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      outValid_d  = outValid_q;
      outResult_d = outResult_q;
      if (flush) begin
         outValid_d = 1'b0;
      end else begin
         unique case (state_q)
            MD_IDLE: begin
               if (in_valid) begin
                  op_d   = in_funct3;
                  sign_d = sfSign;
                  opnd_d = sfMagB;
                  acc_d  = {{XLEN{1'b0}}, sfMagA};
                  cnt_d  = CNT_INIT;
                  if (fastHit) begin
                     outResult_d = fastResult;
                     outValid_d  = 1'b1;
                  end
               end
            end
            MD_CALC: begin
               acc_d = accNext;
               cnt_d = cnt_q - CW'(1);
            end
            MD_FIX: begin
               outResult_d = sfResult;
               outValid_d  = 1'b1;
            end
            MD_DONE: if (out_ready) outValid_d = 1'b0;
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q        <= '0;
         sign_q      <= 1'b0;
         opnd_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         outValid_q  <= 1'b0;
         outResult_q <= '0;
      end else begin
         op_q        <= op_d;
         sign_q      <= sign_d;
         opnd_q      <= opnd_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         outValid_q  <= outValid_d;
         outResult_q <= outResult_d;
      end
   end

   assign out_valid  = outValid_q;
   assign out_result = outResult_q;

endmodule

// File: tb/tb_cpu5_muldiv.sv
// tb_cpu5_muldiv: directed self-checking bench for cpu5_muldiv (XLEN = 32).
module tb_cpu5_muldiv;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_funct3 = 3'b000;
   logic [31:0] in_a = 32'h0;
   logic [31:0] in_b = 32'h0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        busy;

   int checks = 0;
   int failures = 0;

   cpu5_muldiv #(.XLEN(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_funct3  (in_funct3),
      .in_a       (in_a),
      .in_b       (in_b),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Issue one op, wait (bounded) for out_valid, optionally take the result.
   // lat counts sampled cycles after the accept edge, the first one being 1.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input bit take, output logic [31:0] res, output int lat,
                                output bit busyOk, output bit timedOut);
      int k;
      @(negedge clk);
      in_valid  = 1'b1;
      in_funct3 = op;
      in_a      = a;
      in_b      = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 32'hDEADBEEF;
      in_b     = 32'h0;
      lat      = 0;
      busyOk   = 1'b1;
      timedOut = 1'b1;
      k        = 0;
      while (timedOut && k < 100) begin
         k++;
         @(negedge clk);
         if (busy !== 1'b1) busyOk = 1'b0;
         if (out_valid === 1'b1) begin
            lat      = k;
            timedOut = 1'b0;
         end
      end
      res = out_result;
      if (take) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_ready: in_ready=%b busy=%b expected 1/0", in_ready, busy);
      end
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_out: out_valid=%b out_result=%h expected 0/00000000", out_valid, out_result);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic runVectors(input vec_t v[$]);
      logic [31:0] res;
      int          lat;
      bit          busyOk, timedOut;
      foreach (v[i]) begin
         applyStimulus(v[i].op, v[i].a, v[i].b, 1'b1, res, lat, busyOk, timedOut);
         checks++;
         if (timedOut || res !== v[i].exp) begin
            failures++;
            $display("[TB] FAIL %s result: got %h expected %h (timeout=%0d)", v[i].name, res, v[i].exp, timedOut);
         end
         checks++;
         if (lat != v[i].lat) begin
            failures++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
         end
         checks++;
         if (!busyOk) begin
            failures++;
            $display("[TB] FAIL %s busy: dropped before result, expected held high", v[i].name);
         end
      end
   endtask

   task automatic test_mul();
      vec_t v[$];
      v.push_back('{F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_x_m3"});
      v.push_back('{F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min_sq"});
      v.push_back('{F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max_sq"});
      v.push_back('{F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_m1_x_max"});
      v.push_back('{F_MULHU,  32'h80000000, 32'd4,        32'd2,        34, "mulhu_2p31_x4"});
      v.push_back('{F_MUL,    32'h80000000, 32'd4,        32'd0,        34, "mul_2p31_x4"});
      runVectors(v);
   endtask

   task automatic test_div();
      vec_t v[$];
      v.push_back('{F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2"});
      v.push_back('{F_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2"});
      v.push_back('{F_DIVU, 32'd100,      32'd7,        32'd14,       34, "divu_100_7"});
      v.push_back('{F_REMU, 32'd100,      32'd7,        32'd2,        34, "remu_100_7"});
      v.push_back('{F_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_7_m2"});
      v.push_back('{F_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        34, "rem_7_m2"});
      v.push_back('{F_DIV,  32'h80000000, 32'd2,        32'hC0000000, 34, "div_min_2"});
      v.push_back('{F_REMU, 32'hFFFFFFFF, 32'h10,       32'hF,        34, "remu_max_16"});
      runVectors(v);
   endtask

   task automatic test_fastpath();
      vec_t v[$];
      v.push_back('{F_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1, "div_5_0"});
      v.push_back('{F_REM,  32'd5,        32'd0,        32'd5,        1, "rem_5_0"});
      v.push_back('{F_DIVU, 32'h1234,     32'd0,        32'hFFFFFFFF, 1, "divu_x_0"});
      v.push_back('{F_REMU, 32'h1234,     32'd0,        32'h1234,     1, "remu_x_0"});
      v.push_back('{F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf"});
      v.push_back('{F_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "rem_ovf"});
      runVectors(v);
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      int          lat;
      bit          busyOk, timedOut;
      bit          heldOk;
      applyStimulus(F_DIVU, 32'd100, 32'd7, 1'b0, res, lat, busyOk, timedOut);
      checks++;
      if (timedOut || res !== 32'd14) begin
         failures++;
         $display("[TB] FAIL bp_first_result: got %h expected 0000000e", res);
      end
      in_valid  = 1'b1;
      in_funct3 = F_MUL;
      in_a      = 32'd3;
      in_b      = 32'd3;
      heldOk    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b1 || out_result !== 32'd14 || in_ready !== 1'b0) heldOk = 1'b0;
      end
      checks++;
      if (!heldOk) begin
         failures++;
         $display("[TB] FAIL bp_hold: out_valid=%b out_result=%h in_ready=%b expected 1/0000000e/0", out_valid, out_result, in_ready);
      end
      in_funct3 = F_DIVU;
      in_a      = 32'd9;
      in_b      = 32'd0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_bubble: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hFFFFFFFF) begin
         failures++;
         $display("[TB] FAIL bp_next_accept: out_valid=%b out_result=%h expected 1/ffffffff", out_valid, out_result);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      bit seen;
      @(negedge clk);
      in_valid  = 1'b1;
      in_funct3 = F_DIV;
      in_a      = 32'd1000;
      in_b      = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flush_calc: in_ready=%b busy=%b out_valid=%b expected 1/0/0", in_ready, busy, out_valid);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("[TB] FAIL flush_no_result: out_valid seen=1 expected never");
      end
      in_valid  = 1'b1;
      flush     = 1'b1;
      in_funct3 = F_DIV;
      in_a      = 32'd5;
      in_b      = 32'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flush_idle_accept: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] res;
      int          lat;
      bit          busyOk, timedOut;
      @(negedge clk);
      in_valid  = 1'b1;
      in_funct3 = F_MUL;
      in_a      = 32'd11;
      in_b      = 32'd13;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'h0) begin
         failures++;
         $display("[TB] FAIL async_reset: in_ready=%b busy=%b out_valid=%b out_result=%h expected 1/0/0/00000000",
                  in_ready, busy, out_valid, out_result);
      end
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(F_MUL, 32'd5, 32'd6, 1'b1, res, lat, busyOk, timedOut);
      checks++;
      if (timedOut || res !== 32'd30) begin
         failures++;
         $display("[TB] FAIL post_reset_mul: got %h expected 0000001e", res);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_mul();
      test_div();
      test_fastpath();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
